// File: rtl/avr_io_pkg.sv
// Shared IO map, status bit positions, prescaler codes and TX state encoding
// for the AVR data-memory responder.
package avr_io_pkg;

  localparam logic [15:0] ADDR_UCSRA = 16'h002B;
  localparam logic [15:0] ADDR_UDR   = 16'h002C;
  localparam logic [15:0] ADDR_TCNT0 = 16'h0052;
  localparam logic [15:0] ADDR_TCCR0 = 16'h0053;
  localparam logic [15:0] ADDR_TIFR  = 16'h0058;
  localparam logic [15:0] ADDR_TIMSK = 16'h0059;

  localparam int UCSRA_RXC   = 7;
  localparam int UCSRA_UDRE  = 5;
  localparam int UCSRA_RXOVR = 4;
  localparam int UCSRA_TXOVR = 3;
  localparam int TIFR_TOV0   = 0;
  localparam int TIMSK_TOIE0 = 0;

  localparam logic [2:0] CS_STOP    = 3'd0;
  localparam logic [2:0] CS_DIV1    = 3'd1;
  localparam logic [2:0] CS_DIV8    = 3'd2;
  localparam logic [2:0] CS_DIV64   = 3'd3;
  localparam logic [2:0] CS_DIV256  = 3'd4;
  localparam logic [2:0] CS_DIV1024 = 3'd5;

  typedef enum logic {
    TX_EMPTY = 1'b0,
    TX_FULL  = 1'b1
  } tx_state_e;

  function automatic logic [7:0] ucsra_pack(input logic rxc, input logic udre,
                                            input logic rxovr, input logic txovr);
    logic [7:0] v;
    v = '0;
    v[UCSRA_RXC]   = rxc;
    v[UCSRA_UDRE]  = udre;
    v[UCSRA_RXOVR] = rxovr;
    v[UCSRA_TXOVR] = txovr;
    return v;
  endfunction

endpackage

// File: rtl/avr_dmem_if.sv
// Core data bus: the core (master) drives address/dataw/we, the data memory
// (slave) returns rdata one clock later.
interface avr_dmem_if;
  logic [15:0] address;
  logic [7:0]  dataw;
  logic        we;
  logic [7:0]  rdata;

  modport master (output address, output dataw, output we, input rdata);
  modport slave  (input address, input dataw, input we, output rdata);
endinterface

// File: rtl/avr_timer0.sv
// Timer0: 10-bit free prescaler, TCNT0 with overflow flag TOV0, and the
// registered overflow interrupt request.
module avr_timer0
  import avr_io_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] wdata_i,
  input  logic       tcnt_we_i,
  input  logic       tccr_we_i,
  input  logic       tifr_we_i,
  input  logic       timsk_we_i,
  output logic [7:0] tcnt_o,
  output logic [2:0] tccr_o,
  output logic       tov_o,
  output logic       toie_o,
  output logic       irq_o
);

  logic [9:0] presc_q;
  logic [7:0] tcnt_q;
  logic [2:0] tccr_q;
  logic       tov_q;
  logic       toie_q;
  logic       irq_q;
  logic       tick;
  logic       ovf;

  // A tick fires on the clock where the selected prescaler bits are all ones,
  // so a freshly cleared prescaler yields its first tick N clocks later.
  always_comb begin
    tick = 1'b0;
    case (tccr_q)
      CS_DIV1:    tick = 1'b1;
      CS_DIV8:    tick = &presc_q[2:0];
      CS_DIV64:   tick = &presc_q[5:0];
      CS_DIV256:  tick = &presc_q[7:0];
      CS_DIV1024: tick = &presc_q;
      default:    tick = 1'b0;
    endcase
  end

  assign ovf = tick && !tcnt_we_i && (tcnt_q == 8'hFF);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      tcnt_q  <= '0;
      tccr_q  <= CS_STOP;
      tov_q   <= 1'b0;
      toie_q  <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      presc_q <= tccr_we_i ? 10'd0 : presc_q + 10'd1;
      if (tccr_we_i) tccr_q <= wdata_i[2:0];
      if (timsk_we_i) toie_q <= wdata_i[TIMSK_TOIE0];
      if (tcnt_we_i) tcnt_q <= wdata_i;
      else if (tick) tcnt_q <= tcnt_q + 8'd1;
      if (ovf) tov_q <= 1'b1;
      else if (tifr_we_i && wdata_i[TIFR_TOV0]) tov_q <= 1'b0;
      irq_q <= tov_q & toie_q;
    end
  end

  assign tcnt_o = tcnt_q;
  assign tccr_o = tccr_q;
  assign tov_o  = tov_q;
  assign toie_o = toie_q;
  assign irq_o  = irq_q;

endmodule

// File: rtl/avr_dmem.sv
// AVR data-memory responder: SRAM window, UART byte port and (with
// AVR_DMEM_TIMER0_EN defined) timer0, with registered one-cycle read data.
module avr_dmem
  import avr_io_pkg::*;
#(
  parameter logic [15:0] SRAM_BASE = 16'h0060,
  parameter int          SRAM_SIZE = 1024
) (
  input  logic       clock,
  input  logic       reset_n,
  avr_dmem_if.slave  bus,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       irq,
  output tx_state_e  dbg_tx_state
);

  localparam int SRAM_AW = $clog2(SRAM_SIZE);

  logic [15:0]        sram_off;
  logic               sram_hit;
  logic [SRAM_AW-1:0] sram_idx;
  logic [7:0]         mem [SRAM_SIZE];

  logic       wr_ucsra, wr_udr, rd_udr;
  tx_state_e  tx_state_q;
  logic [7:0] tx_data_q;
  logic       tx_valid_q;
  logic       txovr_q;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic       rxc_q, rxc_d;
  logic       rxovr_q, rxovr_d;
  logic [7:0] rdata_q, rdata_d;

  assign sram_off = bus.address - SRAM_BASE;
  assign sram_hit = (bus.address >= SRAM_BASE) && (sram_off < 16'(SRAM_SIZE));
  assign sram_idx = sram_off[SRAM_AW-1:0];

  // A UDR access with we low counts as a read and consumes the RX byte.
  assign wr_ucsra = bus.we && (bus.address == ADDR_UCSRA);
  assign wr_udr   = bus.we && (bus.address == ADDR_UDR);
  assign rd_udr   = !bus.we && (bus.address == ADDR_UDR);

  always_ff @(posedge clock) begin
    if (bus.we && sram_hit) mem[sram_idx] <= bus.dataw;
  end

`ifdef AVR_DMEM_TIMER0_EN
  logic [7:0] tcnt;
  logic [2:0] tccr;
  logic       tov;
  logic       toie;

  avr_timer0 u_timer0 (
    .clock      (clock),
    .reset_n    (reset_n),
    .wdata_i    (bus.dataw),
    .tcnt_we_i  (bus.we && (bus.address == ADDR_TCNT0)),
    .tccr_we_i  (bus.we && (bus.address == ADDR_TCCR0)),
    .tifr_we_i  (bus.we && (bus.address == ADDR_TIFR)),
    .timsk_we_i (bus.we && (bus.address == ADDR_TIMSK)),
    .tcnt_o     (tcnt),
    .tccr_o     (tccr),
    .tov_o      (tov),
    .toie_o     (toie),
    .irq_o      (irq)
  );
`else
  assign irq = 1'b0;
`endif

  // Handshake: tx_valid rises with the byte and holds it stable; the byte
  // transfers on the rising edge where tx_valid && tx_ready, after which the
  // port is free again. A UDR write while a byte is held is dropped (TXOVR).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tx_state_q <= TX_EMPTY;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      txovr_q    <= 1'b0;
    end else begin
      case (tx_state_q)
        TX_EMPTY: begin
          if (wr_udr) begin
            tx_data_q  <= bus.dataw;
            tx_valid_q <= 1'b1;
            tx_state_q <= TX_FULL;
          end
        end
        TX_FULL: begin
          if (tx_ready) begin
            tx_valid_q <= 1'b0;
            tx_state_q <= TX_EMPTY;
          end
        end
        default: begin
          tx_valid_q <= 1'b0;
          tx_state_q <= TX_EMPTY;
        end
      endcase
      if (wr_udr && (tx_state_q == TX_FULL)) txovr_q <= 1'b1;
      else if (wr_ucsra && bus.dataw[UCSRA_TXOVR]) txovr_q <= 1'b0;
    end
  end

  // Set beats write-1-clear; a read racing a new byte returns the old one
  // and leaves RXC set without flagging an overrun.
  always_comb begin
    rx_byte_d = rx_byte_q;
    rxc_d     = rxc_q;
    rxovr_d   = rxovr_q;
    if (wr_ucsra && bus.dataw[UCSRA_RXOVR]) rxovr_d = 1'b0;
    if (rx_valid) begin
      rx_byte_d = rx_data;
      rxc_d     = 1'b1;
      if (rxc_q && !rd_udr) rxovr_d = 1'b1;
    end else if (rd_udr) begin
      rxc_d = 1'b0;
    end
  end

  always_comb begin
    rdata_d = '0;
    if (sram_hit) begin
      rdata_d = mem[sram_idx];
    end else begin
      case (bus.address)
        ADDR_UCSRA: rdata_d = ucsra_pack(rxc_q, tx_state_q == TX_EMPTY, rxovr_q, txovr_q);
        ADDR_UDR:   rdata_d = rx_byte_q;
`ifdef AVR_DMEM_TIMER0_EN
        ADDR_TCNT0: rdata_d = tcnt;
        ADDR_TCCR0: rdata_d = {5'b0, tccr};
        ADDR_TIFR:  rdata_d = {7'b0, tov};
        ADDR_TIMSK: rdata_d = {7'b0, toie};
`endif
        default:    rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_byte_q <= '0;
      rxc_q     <= 1'b0;
      rxovr_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      rx_byte_q <= rx_byte_d;
      rxc_q     <= rxc_d;
      rxovr_q   <= rxovr_d;
      rdata_q   <= rdata_d;
    end
  end

  assign bus.rdata    = rdata_q;
  assign tx_data      = tx_data_q;
  assign tx_valid     = tx_valid_q;
  assign dbg_tx_state = tx_state_q;

endmodule

// File: tb/tb_avr_dmem.sv
// Bench for avr_dmem: bus driver tasks, read-data scoreboard queue, UART and
// timer scenarios (timer checks follow AVR_DMEM_TIMER0_EN).
module tb_avr_dmem;
  import avr_io_pkg::*;

  localparam logic [15:0] SRAM_BASE_TB = 16'h0060;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       irq;
  tx_state_e  dbg_tx_state;

  avr_dmem_if bus ();

  avr_dmem #(.SRAM_BASE(SRAM_BASE_TB), .SRAM_SIZE(1024)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .bus          (bus),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .irq          (irq),
    .dbg_tx_state (dbg_tx_state)
  );

  always #5 clock = ~clock;

  int          total = 0;
  int          bad = 0;
  logic [7:0]  exp_q[$];
  logic [15:0] addr_q[$];
  logic        rd_pend = 1'b0;
  logic [7:0]  tx_q[$];
  logic [7:0]  model [1024];
  int          idx_list[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // One bus cycle: drive at the falling edge, the DUT samples on the next
  // rising edge, and the read driven one cycle earlier is scored here.
  task automatic step(input logic [15:0] a, input logic w, input logic [7:0] d,
                      input logic rd, input logic [7:0] e);
    logic [7:0]  pe;
    logic [15:0] pa;
    @(negedge clock);
    if (rd_pend) begin
      pe = exp_q.pop_front();
      pa = addr_q.pop_front();
      check($sformatf("rdata@%04h", pa), 32'(bus.rdata), 32'(pe));
    end
    rd_pend     = rd;
    bus.address = a;
    bus.we      = w;
    bus.dataw   = d;
    if (rd) begin
      exp_q.push_back(e);
      addr_q.push_back(a);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    step(a, 1'b1, d, 1'b0, 8'h00);
  endtask

  task automatic rd(input logic [15:0] a, input logic [7:0] e);
    step(a, 1'b0, 8'h00, 1'b1, e);
  endtask

  task automatic idle_cyc(input int n);
    for (int i = 0; i < n; i++) step(16'h0000, 1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic rx_pulse(input logic [7:0] d);
    rx_data  = d;
    rx_valid = 1'b1;
    idle_cyc(1);
    rx_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] b;
    int         idx;
    reset_n     = 1'b0;
    bus.address = 16'h0000;
    bus.we      = 1'b0;
    bus.dataw   = 8'h00;
    tx_ready    = 1'b0;
    rx_valid    = 1'b0;
    rx_data     = 8'h00;
    repeat (3) @(negedge clock);
    check("rst_rdata", 32'(bus.rdata), 0);
    check("rst_tx_valid", 32'(tx_valid), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_irq", 32'(irq), 0);
    check("rst_state", 32'(dbg_tx_state), 32'(TX_EMPTY));
    reset_n = 1'b1;
    rd(ADDR_UCSRA, 8'h20);
    rd(ADDR_TCNT0, 8'h00);

    // SRAM window edges, outside the window, and read-before-write
    wr(16'h0060, 8'hA5);
    wr(16'h045F, 8'h5A);
    rd(16'h0060, 8'hA5);
    rd(16'h045F, 8'h5A);
    rd(16'h0460, 8'h00);
    step(16'h0060, 1'b1, 8'h11, 1'b1, 8'hA5);
    rd(16'h0060, 8'h11);
    for (int k = 0; k < 12; k++) begin
      idx = $urandom_range(0, 1023);
      b   = 8'($urandom_range(0, 255));
      model[idx] = b;
      idx_list.push_back(idx);
      wr(16'(SRAM_BASE_TB + 16'(idx)), b);
    end
    foreach (idx_list[k]) rd(16'(SRAM_BASE_TB + 16'(idx_list[k])), model[idx_list[k]]);

    wr(16'h0010, 8'hFF);
    rd(16'h0010, 8'h00);
    rd(16'h002D, 8'h00);
    rd(16'hFFFF, 8'h00);

    // TX backpressure and overrun
    wr(ADDR_UDR, 8'h41);
    for (int k = 0; k < 5; k++) begin
      idle_cyc(1);
      check("tx_hold_valid", 32'(tx_valid), 1);
      check("tx_hold_data", 32'(tx_data), 32'h41);
    end
    check("tx_state_full", 32'(dbg_tx_state), 32'(TX_FULL));
    rd(ADDR_UCSRA, 8'h00);
    wr(ADDR_UDR, 8'h42);
    rd(ADDR_UCSRA, 8'h08);
    idle_cyc(1);
    check("tx_data_kept", 32'(tx_data), 32'h41);
    tx_ready = 1'b1;
    idle_cyc(1);
    tx_ready = 1'b0;
    check("tx_accept", 32'(tx_valid), 0);
    rd(ADDR_UCSRA, 8'h28);
    wr(ADDR_UCSRA, 8'h08);
    rd(ADDR_UCSRA, 8'h20);

    // UDR write on the acceptance edge is dropped
    wr(ADDR_UDR, 8'h55);
    idle_cyc(1);
    check("tx_data_55", 32'(tx_data), 32'h55);
    wr(ADDR_UDR, 8'h66);
    tx_ready = 1'b1;
    idle_cyc(1);
    tx_ready = 1'b0;
    check("tx_same_cycle_valid", 32'(tx_valid), 0);
    check("tx_same_cycle_data", 32'(tx_data), 32'h55);
    rd(ADDR_UCSRA, 8'h28);
    wr(ADDR_UCSRA, 8'h08);

    for (int k = 0; k < 4; k++) begin
      b = 8'($urandom_range(0, 255));
      tx_q.push_back(b);
      wr(ADDR_UDR, b);
      idle_cyc(1 + $urandom_range(0, 3));
      check("txr_valid", 32'(tx_valid), 1);
      check("txr_data", 32'(tx_data), 32'(tx_q.pop_front()));
      tx_ready = 1'b1;
      idle_cyc(1);
      tx_ready = 1'b0;
      check("txr_done", 32'(tx_valid), 0);
    end
    rd(ADDR_UCSRA, 8'h20);

    // RX overrun, read clearing RXC, and read racing a new byte
    rx_pulse(8'h37);
    rx_pulse(8'h38);
    rd(ADDR_UCSRA, ucsra_pack(1'b1, 1'b1, 1'b1, 1'b0));
    rd(ADDR_UDR, 8'h38);
    rd(ADDR_UCSRA, 8'h30);
    wr(ADDR_UCSRA, 8'h10);
    rd(ADDR_UCSRA, 8'h20);
    rx_pulse(8'h44);
    rd(ADDR_UDR, 8'h44);
    rx_pulse(8'h45);
    rd(ADDR_UCSRA, 8'hA0);
    rd(ADDR_UDR, 8'h45);
    rd(ADDR_UCSRA, 8'h20);

`ifdef AVR_DMEM_TIMER0_EN
    wr(ADDR_TCCR0, 8'h00);
    wr(ADDR_TIFR, 8'h01);
    wr(ADDR_TCNT0, 8'hFE);
    wr(ADDR_TIMSK, 8'h01);
    wr(ADDR_TCCR0, 8'h01);
    idle_cyc(2);
    check("irq_before_ovf", 32'(irq), 0);
    rd(ADDR_TIFR, 8'h01);
    check("irq_lags_tov", 32'(irq), 0);
    idle_cyc(1);
    check("irq_set", 32'(irq), 1);
    wr(ADDR_TIFR, 8'h01);
    idle_cyc(2);
    check("irq_cleared", 32'(irq), 0);
    rd(ADDR_TIFR, 8'h00);
    wr(ADDR_TCNT0, 8'hFE);
    idle_cyc(1);
    wr(ADDR_TIFR, 8'h01);
    rd(ADDR_TIFR, 8'h01);
    rd(ADDR_TCNT0, 8'h01);
    wr(ADDR_TCNT0, 8'h10);
    rd(ADDR_TCNT0, 8'h10);
    wr(ADDR_TIFR, 8'h01);
    wr(ADDR_TCNT0, 8'hFF);
    wr(ADDR_TCNT0, 8'h20);
    rd(ADDR_TIFR, 8'h00);
    rd(ADDR_TCNT0, 8'h21);
    wr(ADDR_TCCR0, 8'h00);
    wr(ADDR_TCNT0, 8'h00);
    wr(ADDR_TCCR0, 8'h02);
    idle_cyc(60);
    rd(ADDR_TCNT0, 8'h07);
    idle_cyc(3);
    rd(ADDR_TCNT0, 8'h08);
    rd(ADDR_TCCR0, 8'h02);
    wr(ADDR_TCCR0, 8'h06);
    wr(ADDR_TCNT0, 8'h05);
    idle_cyc(20);
    rd(ADDR_TCNT0, 8'h05);
    rd(ADDR_TIMSK, 8'h01);
`else
    wr(ADDR_TCNT0, 8'h12);
    rd(ADDR_TCNT0, 8'h00);
    wr(ADDR_TIMSK, 8'h01);
    rd(ADDR_TIMSK, 8'h00);
    wr(ADDR_TCCR0, 8'h01);
    idle_cyc(4);
    rd(ADDR_TCNT0, 8'h00);
    check("irq_tied", 32'(irq), 0);
`endif

    // Reset while a byte is held
    wr(ADDR_UDR, 8'h77);
    idle_cyc(2);
    check("pre_rst_valid", 32'(tx_valid), 1);
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(tx_valid), 0);
    check("async_rst_data", 32'(tx_data), 0);
    @(negedge clock);
    check("async_rst_rdata", 32'(bus.rdata), 0);
    reset_n = 1'b1;
    rd(ADDR_UCSRA, 8'h20);
    rd(ADDR_TCNT0, 8'h00);
    idle_cyc(2);
    check("post_rst_valid", 32'(tx_valid), 0);
    check("post_rst_irq", 32'(irq), 0);
    check("sb_empty", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
